c_ram_banked: RTL and testbench
===============================

Name: c_ram_banked

Overview:
Parametrised banked RAM that generalises the fixed-size Hack RAM hierarchy. Word depth and width are set by parameters. It adds a registered read port with a valid flag and a hardware clear sequencer that zeroes every word after reset or on request. It replaces hand-instantiated RAM trees as the data memory behind the CPU and as a scratch buffer for the video path.

Parameters:
DATA_W, 16, word width in bits
BANK_AW, 3, bank-select address bits; bank count is 2**BANK_AW
WORD_AW, 9, word address bits within a bank; bank depth is 2**WORD_AW
AW, BANK_AW+WORD_AW, total address width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
in  in  DATA_W  write data
load  in  1  write strobe; writes `in` to `address` at the edge
rd_en  in  1  read strobe
address  in  AW  word address; [AW-1:WORD_AW] selects the bank, [WORD_AW-1:0] selects the word
clear  in  1  request a full zero sweep
out  out  DATA_W  registered read data
out_valid  out  1  `out` holds the data from the previous cycle's accepted read
busy  out  1  clear sweep in progress; load, rd_en and clear are ignored while high

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=CLEAR, sweep counter=0, busy=1, out=0, out_valid=0.
  - Memory array is not reset directly; the sweep zeroes it.
- States:
  - CLEAR: each cycle writes 0 to word[counter], then counter increments. Takes exactly 2**AW cycles after reset release. The write of word 2**AW-1 is followed by state=IDLE and busy=0 at the next edge. The counter wraps to 0.
  - IDLE: normal access.
- IDLE priority, highest first:
  - clear=1: enter CLEAR next edge, busy=1 next cycle. A load or rd_en in the same cycle is dropped (no write, out_valid=0 next cycle).
  - Otherwise load and rd_en act independently.
- Write: load=1 in IDLE writes `in` to the bank decoded from address[AW-1:WORD_AW], word address[WORD_AW-1:0]. Only one bank's write enable is asserted.
- Read:
  - rd_en=1 in IDLE gives out=mem[address] and out_valid=1 on the next cycle (latency 1).
  - rd_en=0 gives out_valid=0 next cycle; out holds its last value.
  - Output mux selects using the bank index registered with the read, not the current address.
- Read/write same address, same cycle: write-first; out returns the new `in` value.
- Read/write different addresses, same cycle: both happen; no interference.
- While busy: rd_en is ignored (out_valid stays 0); load and clear are ignored.
- Reset asserted mid-sweep or mid-access: immediate return to the reset values above; the sweep restarts from word 0 after release.
- Address width is exact: no out-of-range addresses exist, no wrap logic is needed.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CLEAR} (1 bit);
  - default width constants DATA_W_DEF=16, BANK_AW_DEF=3, WORD_AW_DEF=9.
- Sub-module c_ram_bank (params DATA_W, WORD_AW):
  - one synchronous-write array of 2**WORD_AW words;
  - inputs we, waddr, wdata, re, raddr;
  - registered rdata with same-address write-first bypass.
- Top level contains:
  - generate loop of 2**BANK_AW c_ram_bank instances;
  - load decoder;
  - clear FSM and counter (counter drives the write address and forces wdata=0 during CLEAR);
  - registered bank index;
  - output mux;
  - out_valid register.

Test Plan:
1. Bench params DATA_W=16, BANK_AW=2, WORD_AW=3 (32 words). Release reset -> busy=1 for exactly 32 cycles, then 0; a read of every address returns 0x0000 with out_valid=1 one cycle after each rd_en.
2. Write 0xBEEF @5 and 0x1234 @29, then read @5, @29, @6 -> out 0xBEEF, 0x1234, 0x0000, each one cycle after its rd_en; confirms bank decode, since 5 and 29 sit in different banks at the same word offset.
3. load=1, rd_en=1, address=12, in=0xA5A5 in the same cycle -> next cycle out=0xA5A5, out_valid=1; a following read of 12 returns 0xA5A5.
4. Fill all words with their address, pulse clear with load=1 @3, in=0xFFFF -> write dropped; busy=1 for 32 cycles; rd_en during busy gives out_valid=0; afterwards every address reads 0x0000.
5. Assert reset_n=0 at sweep cycle 10 -> out=0, out_valid=0, busy=1 immediately; after release, busy stays high for a full 32 cycles.
6. Back-to-back reads of 3, 11, 19, 27 on consecutive cycles with distinct stored values -> out tracks each value with 1-cycle latency and out_valid held at 1; confirms the registered bank index.

Source files
------------

// File: rtl/c_ram_banked_pkg.sv
// Shared types and default geometry for the banked RAM.
package c_ram_banked_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned BANK_AW_DEF = 3;
    localparam int unsigned WORD_AW_DEF = 9;

endpackage

// File: rtl/c_ram_banked_bank.sv
// One RAM bank: synchronous write, registered read with write-first bypass.
module c_ram_bank #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WORD_AW = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [WORD_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               re,
    input  logic [WORD_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    localparam int unsigned Depth = 2 ** WORD_AW;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds between reads so the top-level mux can keep showing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/c_ram_banked.sv
// Banked RAM with 1-cycle registered read, valid flag and a zeroing sweep
// that runs after reset or on a clear request.
module c_ram_banked
    import c_ram_banked_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BANK_AW = BANK_AW_DEF,
    parameter int unsigned WORD_AW = WORD_AW_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          in,
    input  logic                       load,
    input  logic                       rd_en,
    input  logic [BANK_AW+WORD_AW-1:0] address,
    input  logic                       clear,
    output logic [DATA_W-1:0]          out,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int unsigned AW    = BANK_AW + WORD_AW;
    localparam int unsigned NBank = 2 ** BANK_AW;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [BANK_AW-1:0] bank_sel_q;
    logic              out_valid_q;

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [BANK_AW-1:0] addr_bank;
    logic [WORD_AW-1:0] addr_word;
    logic [AW-1:0]     waddr_full;
    logic [DATA_W-1:0] wdata;
    logic              wr_any;

    logic [DATA_W-1:0] bank_rdata [NBank];

    assign addr_bank = address[AW-1:WORD_AW];
    assign addr_word = address[WORD_AW-1:0];

    // A clear request in IDLE swallows any access issued in the same cycle.
    assign accept = (state_q == IDLE) && !clear;
    assign wr_acc = accept && load;
    assign rd_acc = accept && rd_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        waddr_full = address;
        wdata      = in;
        wr_any     = wr_acc;
        if (state_q == CLEAR) begin
            waddr_full = cnt_q;
            wdata      = '0;
            wr_any     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            bank_sel_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                bank_sel_q <= addr_bank;
            end
        end
    end

    for (genvar b = 0; b < NBank; b++) begin : g_bank
        c_ram_bank #(
            .DATA_W  (DATA_W),
            .WORD_AW (WORD_AW)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (wr_any && (waddr_full[AW-1:WORD_AW] == BANK_AW'(b))),
            .waddr   (waddr_full[WORD_AW-1:0]),
            .wdata   (wdata),
            .re      (rd_acc && (addr_bank == BANK_AW'(b))),
            .raddr   (addr_word),
            .rdata   (bank_rdata[b])
        );
    end

    assign out       = bank_rdata[bank_sel_q];
    assign out_valid = out_valid_q;
    assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_c_ram_banked.sv
// Randomised bench for c_ram_banked against an array-based behavioural model.
module tb_c_ram_banked;

    localparam int DW  = 16;
    localparam int BAW = 2;
    localparam int WAW = 3;
    localparam int AW  = BAW + WAW;
    localparam int N   = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          load = 1'b0;
    logic          rd_en = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic          busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    c_ram_banked #(
        .DATA_W  (DW),
        .BANK_AW (BAW),
        .WORD_AW (WAW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (din),
        .load      (load),
        .rd_en     (rd_en),
        .address   (address),
        .clear     (clear),
        .out       (dout),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // Model: a sweep just makes the array all-zero and blocks access for N cycles.
    logic [DW-1:0] m_mem [N];
    int            m_left;
    logic [DW-1:0] m_out;
    logic          m_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left  <= N;
            m_out   <= '0;
            m_valid <= 1'b0;
            for (int i = 0; i < N; i++) m_mem[i] <= '0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_valid <= 1'b0;
        end else if (clear) begin
            m_left  <= N;
            m_valid <= 1'b0;
            for (int i = 0; i < N; i++) m_mem[i] <= '0;
        end else begin
            if (load) m_mem[address] <= din;
            m_valid <= rd_en;
            if (rd_en) m_out <= load ? din : m_mem[address];
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {31'b0, busy}, {31'b0, m_left > 0});
            cmp("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            cmp("out", {16'b0, dout}, {16'b0, m_out});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        address = AW'(a);
        din     = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [DW-1:0] exp);
        address = AW'(a);
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        cmp(nm, {16'b0, dout}, {16'b0, exp});
        cmp({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_sweep(input string nm, input logic rand_rd);
        int n = 0;
        while (busy && n < 200) begin
            rd_en = rand_rd ? 1'($urandom) : 1'b0;
            address = AW'($urandom);
            tick();
            n++;
        end
        rd_en = 1'b0;
        cmp(nm, n, 32'd32);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] vals [4];
        int            addrs [4];
        vals  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        addrs = '{3, 11, 19, 27};

        tick();
        chk_en = 1'b1;
        tick();
        cmp("rst_busy", {31'b0, busy}, 32'd1);
        cmp("rst_valid", {31'b0, out_valid}, 32'd0);
        cmp("rst_out", {16'b0, dout}, 32'd0);
        reset_n = 1'b1;

        // 1: initial sweep length and zeroed contents
        wait_sweep("sweep_after_reset", 1'b0);
        for (int a = 0; a < N; a++) rd_chk("zero_read", a, 16'h0000);

        // 2: bank decode, same word offset in different banks
        wr(5, 16'hBEEF);
        wr(29, 16'h1234);
        rd_chk("rd5", 5, 16'hBEEF);
        rd_chk("rd29", 29, 16'h1234);
        rd_chk("rd6", 6, 16'h0000);

        // 3: write-first on same address
        address = AW'(12);
        din = 16'hA5A5;
        load = 1'b1;
        rd_chk("wr_first", 12, 16'hA5A5);
        load = 1'b0;
        rd_chk("rd12", 12, 16'hA5A5);

        // 4: clear drops a concurrent write and zeroes everything
        for (int a = 0; a < N; a++) wr(a, DW'(a));
        rd_chk("filled", 17, 16'd17);
        address = AW'(3);
        din = 16'hFFFF;
        load = 1'b1;
        clear = 1'b1;
        tick();
        load = 1'b0;
        clear = 1'b0;
        wait_sweep("sweep_after_clear", 1'b1);
        for (int a = 0; a < N; a++) rd_chk("cleared", a, 16'h0000);

        // 5: reset mid-sweep restarts the full sweep
        wr(7, 16'h5555);
        rd_chk("pre_rst", 7, 16'h5555);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        cmp("midrst_busy", {31'b0, busy}, 32'd1);
        cmp("midrst_valid", {31'b0, out_valid}, 32'd0);
        cmp("midrst_out", {16'b0, dout}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_sweep("sweep_after_midrst", 1'b0);

        // 6: back-to-back reads across banks
        for (int i = 0; i < 4; i++) wr(addrs[i], vals[i]);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = AW'(addrs[i]);
            tick();
            cmp("b2b_out", {16'b0, dout}, {16'b0, vals[i]});
            cmp("b2b_valid", {31'b0, out_valid}, 32'd1);
        end
        rd_en = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            address = AW'($urandom);
            din     = DW'($urandom);
            load    = 1'($urandom);
            rd_en   = 1'($urandom);
            clear   = ($urandom_range(0, 99) == 0);
            tick();
        end
        load  = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
